// File: rtl/flow_step_ctrl.sv
// Step-pulse, direction and run/pause controller for the rotating LED display, driven by three debounced keys.
// Optional FLOW_STEP_SINGLE_EN: while paused, a speed press emits one single-step pulse instead of changing speed.
module flow_step_ctrl #(
    parameter int BASE_PERIOD  = 10000000,
    parameter int DEBOUNCE_CYC = 1000000
) (
    input  logic       sys_clk50,
    input  logic       rst_n,
    input  logic       key_speed_n,
    input  logic       key_dir_n,
    input  logic       key_pause_n,
    output logic       step,
    output logic       dir,
    output logic       run,
    output logic [1:0] speed
);
    localparam int CNT_W = $clog2(BASE_PERIOD);
    localparam int DB_W  = $clog2(DEBOUNCE_CYC);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYC - 1);

    localparam int K_SPEED = 0;
    localparam int K_DIR   = 1;
    localparam int K_PAUSE = 2;

    typedef enum logic {
        S_RUN   = 1'b0,
        S_PAUSE = 1'b1
    } state_t;

    logic [2:0]       keys_raw;
    logic [2:0]       sync1_q;
    logic [2:0]       sync2_q;
    logic [2:0]       stable_q;
    logic [2:0]       stable_d;
    logic [2:0]       press;
    logic [DB_W-1:0]  deb_cnt_q [3];
    logic [DB_W-1:0]  deb_cnt_d [3];

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] period_m1;
    logic             step_q;
    logic             dir_q;
    logic [1:0]       speed_q;

    assign keys_raw = {key_pause_n, key_dir_n, key_speed_n};

    // A press is the 1->0 edge of the debounced state, seen one cycle before stable_q updates.
    always_comb begin
        stable_d = stable_q;
        press    = '0;
        for (int k = 0; k < 3; k++) begin
            deb_cnt_d[k] = '0;
            if (sync2_q[k] != stable_q[k]) begin
                if (deb_cnt_q[k] == DB_LAST) begin
                    stable_d[k] = sync2_q[k];
                    press[k]    = ~sync2_q[k];
                end else begin
                    deb_cnt_d[k] = deb_cnt_q[k] + DB_W'(1);
                end
            end
        end
    end

    always_ff @(posedge sys_clk50 or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q  <= '1;
            sync2_q  <= '1;
            stable_q <= '1;
            for (int k = 0; k < 3; k++) begin
                deb_cnt_q[k] <= '0;
            end
        end else begin
            sync1_q  <= keys_raw;
            sync2_q  <= sync1_q;
            stable_q <= stable_d;
            for (int k = 0; k < 3; k++) begin
                deb_cnt_q[k] <= deb_cnt_d[k];
            end
        end
    end

    always_comb begin
        period_m1 = CNT_W'((BASE_PERIOD >> speed_q) - 1);
    end

    // Later assignments override the expiry wrap, so a speed press always restarts the period.
    always_ff @(posedge sys_clk50 or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_RUN;
            cnt_q   <= '0;
            step_q  <= 1'b0;
            dir_q   <= 1'b0;
            speed_q <= 2'd0;
        end else begin
            step_q <= 1'b0;
            case (state_q)
                S_RUN: begin
                    if (cnt_q == period_m1) begin
                        step_q <= 1'b1;
                        cnt_q  <= '0;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                    if (press[K_SPEED]) begin
                        cnt_q   <= '0;
                        speed_q <= speed_q + 2'd1;
                    end
                    if (press[K_PAUSE]) begin
                        state_q <= S_PAUSE;
                    end
                end
                S_PAUSE: begin
`ifdef FLOW_STEP_SINGLE_EN
                    if (press[K_SPEED]) begin
                        step_q <= 1'b1;
                    end
`else
                    if (press[K_SPEED]) begin
                        cnt_q   <= '0;
                        speed_q <= speed_q + 2'd1;
                    end
`endif
                    if (press[K_PAUSE]) begin
                        state_q <= S_RUN;
                    end
                end
                default: state_q <= S_RUN;
            endcase
            if (press[K_DIR]) begin
                dir_q <= ~dir_q;
            end
        end
    end

    assign step  = step_q;
    assign dir   = dir_q;
    assign run   = (state_q == S_RUN);
    assign speed = speed_q;

endmodule
